// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions used by the ID/EX stage and its forwarding muxes.
//   alu_op_e  : 3-bit ALU opcode carried from decode to the ALU (ADD=000 .. SRL=111)
//   fwd_sel_e : operand source chosen by a forwarding mux (REG, MEM, WB)
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Purely combinational operand-forwarding mux for one source register.
// A MEM-stage producer is younger than a WB-stage producer, so a MEM match
// wins. Register x0 is hard-wired zero and is never forwarded.
// Ports:
//   rs_i           source register address held in the ID/EX register
//   reg_data_i     register-file data captured with that instruction
//   mem_rd_i, mem_reg_write_i, mem_result_i   MEM-stage producer
//   wb_rd_i,  wb_reg_write_i,  wb_result_i    WB-stage producer
//   data_o         selected operand
// -----------------------------------------------------------------------------
module fwd_mux
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [REGW-1:0] mem_rd_i,
    input  logic            mem_reg_write_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic [REGW-1:0] wb_rd_i,
    input  logic            wb_reg_write_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic [XLEN-1:0] data_o
);

    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel;

    assign mem_hit = mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
    assign wb_hit  = wb_reg_write_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        case (sel)
            FWD_MEM: data_o = mem_result_i;
            FWD_WB:  data_o = wb_result_i;
            default: data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with operand forwarding and load-use detection.
// Decode fields are captured on each rising clk unless stalled; flush (or an
// invalid decode slot) captures a bubble. ALU operands are produced from the
// registered fields through two fwd_mux instances (rs1, rs2).
//
// Configuration macro ID_EX_FORWARDING_EN:
//   defined   - MEM/WB results are forwarded; load_use_stall flags only loads.
//   undefined - operands come from registered register data only, mem_*/wb_*
//               inputs are ignored, and load_use_stall flags any RAW on a
//               register-writing EX instruction.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   id_*                               decode-stage instruction fields
//   stall, flush                       hold register / insert bubble (flush wins)
//   mem_rd/mem_reg_write/mem_result    MEM-stage forwarding source
//   wb_rd/wb_reg_write/wb_result       WB-stage forwarding source
//   ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_pc, ex_rd,
//   ex_reg_write, ex_mem_read, ex_mem_write   execute-stage outputs
//   load_use_stall                     hazard request to the hazard unit
//
// Handshake: there is no valid/ready pair; ex_valid qualifies every ex_*
// output in the cycle it is high, and the upstream hazard unit is expected to
// answer load_use_stall with stall=1 and flush=1 in the same cycle.
// -----------------------------------------------------------------------------
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [2:0]      id_alu_control,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic [REGW-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [REGW-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            load_use_stall
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        alu_op_e         alu_control;
        logic            alu_src;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    ex_reg_t id_pkt;

    always_comb begin
        id_pkt             = '0;
        id_pkt.valid       = 1'b1;
        id_pkt.pc          = id_pc;
        id_pkt.rs1_data    = id_rs1_data;
        id_pkt.rs2_data    = id_rs2_data;
        id_pkt.imm         = id_imm;
        id_pkt.rs1         = id_rs1;
        id_pkt.rs2         = id_rs2;
        id_pkt.rd          = id_rd;
        id_pkt.alu_control = alu_op_e'(id_alu_control);
        id_pkt.alu_src     = id_alu_src;
        id_pkt.reg_write   = id_reg_write;
        id_pkt.mem_read    = id_mem_read;
        id_pkt.mem_write   = id_mem_write;
    end

    // Flush beats stall; an empty decode slot is only captured when not stalled.
    // A bubble clears the whole entry so no stale data leaks onto the operands.
    always_comb begin
        ex_d = ex_q;
        if (flush || (!stall && !id_valid)) begin
            ex_d             = '0;
            ex_d.alu_control = ALU_ADD;
        end else if (!stall) begin
            ex_d = id_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding sources seen by the muxes; tied off when forwarding is built out.
    logic [REGW-1:0] fwd_mem_rd;
    logic            fwd_mem_we;
    logic [XLEN-1:0] fwd_mem_res;
    logic [REGW-1:0] fwd_wb_rd;
    logic            fwd_wb_we;
    logic [XLEN-1:0] fwd_wb_res;
    logic            hazard_src;

`ifdef ID_EX_FORWARDING_EN
    assign fwd_mem_rd  = mem_rd;
    assign fwd_mem_we  = mem_reg_write;
    assign fwd_mem_res = mem_result;
    assign fwd_wb_rd   = wb_rd;
    assign fwd_wb_we   = wb_reg_write;
    assign fwd_wb_res  = wb_result;
    // ALU results are forwarded, so only a load still in EX forces a bubble.
    assign hazard_src  = ex_q.mem_read;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_rd, mem_reg_write, mem_result,
                                 wb_rd, wb_reg_write, wb_result};
    assign fwd_mem_rd  = '0;
    assign fwd_mem_we  = 1'b0;
    assign fwd_mem_res = '0;
    assign fwd_wb_rd   = '0;
    assign fwd_wb_we   = 1'b0;
    assign fwd_wb_res  = '0;
    // Without forwarding any register-writing EX instruction is a hazard.
    assign hazard_src  = ex_q.reg_write;
`endif

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs_i            (ex_q.rs1),
        .reg_data_i      (ex_q.rs1_data),
        .mem_rd_i        (fwd_mem_rd),
        .mem_reg_write_i (fwd_mem_we),
        .mem_result_i    (fwd_mem_res),
        .wb_rd_i         (fwd_wb_rd),
        .wb_reg_write_i  (fwd_wb_we),
        .wb_result_i     (fwd_wb_res),
        .data_o          (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs_i            (ex_q.rs2),
        .reg_data_i      (ex_q.rs2_data),
        .mem_rd_i        (fwd_mem_rd),
        .mem_reg_write_i (fwd_mem_we),
        .mem_result_i    (fwd_mem_res),
        .wb_rd_i         (fwd_wb_rd),
        .wb_reg_write_i  (fwd_wb_we),
        .wb_result_i     (fwd_wb_res),
        .data_o          (rs2_fwd)
    );

    assign load_use_stall = ex_q.valid && hazard_src && (ex_q.rd != '0) && id_valid &&
                            ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    assign ex_valid      = ex_q.valid;
    assign alu_a         = rs1_fwd;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : rs2_fwd;
    assign alu_control   = ex_q.alu_control;
    assign ex_store_data = rs2_fwd;
    assign ex_pc         = ex_q.pc;
    assign ex_rd         = ex_q.rd;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. The driver sets inputs just after each rising
// edge and pushes the hand-computed output image expected at the following
// falling edge; a monitor pops and compares on every falling edge.
// Expectations that differ with ID_EX_FORWARDING_EN select on FWD_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int EW   = 141;

`ifdef ID_EX_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            id_valid = 1'b0;
    logic [XLEN-1:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [REGW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [2:0]      id_alu_control = '0;
    logic            id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic            stall = 1'b0, flush = 1'b0;
    logic [REGW-1:0] mem_rd = '0, wb_rd = '0;
    logic            mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [XLEN-1:0] mem_result = '0, wb_result = '0;

    logic            ex_valid;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [2:0]      alu_control;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_stall(load_use_stall)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] msk_q[$];
    string         name_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic logic [EW-1:0] mk(input logic v, input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] ctl, input logic [31:0] sd,
                                         input logic [31:0] pc, input logic [4:0] rd,
                                         input logic rw, input logic mr, input logic mw,
                                         input logic lus);
        return {v, a, b, ctl, sd, pc, rd, rw, mr, mw, lus};
    endfunction

    logic [EW-1:0] m_all;
    logic [EW-1:0] m_ctrl;
    logic [EW-1:0] got_vec;

    assign got_vec = {ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_pc,
                      ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] e, m;
            string         nm;
            e  = exp_q.pop_front();
            m  = msk_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ((got_vec & m) !== (e & m)) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h (mask %h)", nm, got_vec & m, e & m, m);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [EW-1:0] e, input logic [EW-1:0] m);
        exp_q.push_back(e);
        msk_q.push_back(m);
        name_q.push_back(nm);
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic [2:0] ctl, input logic src, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alu_control = ctl;
        id_alu_src = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
                           input logic [4:0] wrd, input logic wwe, input logic [31:0] wres);
        mem_rd = mrd; mem_reg_write = mwe; mem_result = mres;
        wb_rd = wrd; wb_reg_write = wwe; wb_result = wres;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_all  = '1;
        m_ctrl = mk(1'b1, 32'h0, 32'h0, 3'b111, 32'h0, 32'h0, 5'h1f, 1'b1, 1'b1, 1'b1, 1'b1);

        cycle();
        // reset held from time zero
        expect_out("reset_init", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_all);
        cycle();

        rst_n = 1'b1;
        set_id(1, 32'h100, 32'd5, 32'd9, 32'd7, 5'd1, 5'd2, 5'd3, 3'b000, 1, 1, 0, 0);
        expect_out("idle_after_reset", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_all);
        cycle();

        set_id(1, 32'h104, 32'h20, 32'h30, 32'h40, 5'd5, 5'd6, 5'd7, 3'b001, 0, 1, 0, 0);
        expect_out("basic_capture", mk(1, 32'd5, 32'd7, 3'b000, 32'd9, 32'h100, 5'd3, 1, 0, 0, 0), m_all);
        cycle();

        set_id(1, 32'h108, 32'h11, 32'h22, 32'h8, 5'd3, 5'd4, 5'd0, 3'b000, 1, 0, 0, 1);
        expect_out("reg_operands", mk(1, 32'h20, 32'h30, 3'b001, 32'h30, 32'h104, 5'd7, 1, 0, 0, 0), m_all);
        cycle();

        // store with ex_rs1=3, ex_rs2=4 held by stall while forwarding sources vary
        stall = 1'b1;
        set_id(1, 32'h200, 32'h99, 32'h98, 32'h97, 5'd9, 5'd10, 5'd11, 3'b010, 0, 1, 0, 0);
        set_fwd(5'd3, 1, 32'hAA, 5'd3, 1, 32'hBB);
        expect_out("fwd_mem_priority",
                   mk(1, FWD_EN ? 32'hAA : 32'h11, 32'h8, 3'b000, 32'h22, 32'h108, 5'd0, 0, 0, 1, 0), m_all);
        cycle();

        set_id(1, 32'h204, 32'h91, 32'h92, 32'h93, 5'd12, 5'd13, 5'd14, 3'b110, 1, 0, 1, 0);
        set_fwd(5'd3, 0, 32'hAA, 5'd3, 1, 32'hBB);
        expect_out("fwd_wb",
                   mk(1, FWD_EN ? 32'hBB : 32'h11, 32'h8, 3'b000, 32'h22, 32'h108, 5'd0, 0, 0, 1, 0), m_all);
        cycle();

        set_id(1, 32'h208, 32'h81, 32'h82, 32'h83, 5'd15, 5'd16, 5'd17, 3'b101, 0, 1, 0, 1);
        set_fwd(5'd0, 1, 32'hAA, 5'd3, 0, 32'hBB);
        expect_out("mem_rd_zero_no_fwd",
                   mk(1, 32'h11, 32'h8, 3'b000, 32'h22, 32'h108, 5'd0, 0, 0, 1, 0), m_all);
        cycle();

        set_id(1, 32'h20c, 32'h71, 32'h72, 32'h73, 5'd18, 5'd19, 5'd20, 3'b111, 1, 1, 1, 0);
        set_fwd(5'd4, 1, 32'hAA, 5'd0, 0, 32'hBB);
        expect_out("fwd_rs2_store",
                   mk(1, 32'h11, 32'h8, 3'b000, FWD_EN ? 32'hAA : 32'h22, 32'h108, 5'd0, 0, 0, 1, 0), m_all);
        cycle();

        // release stall; next instruction is a load to x4
        stall = 1'b0;
        set_fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
        set_id(1, 32'h300, 32'h50, 32'h60, 32'h70, 5'd1, 5'd2, 5'd4, 3'b000, 1, 1, 1, 0);
        expect_out("stall_release_hold",
                   mk(1, 32'h11, 32'h8, 3'b000, 32'h22, 32'h108, 5'd0, 0, 0, 1, 0), m_all);
        cycle();

        // dependent instruction reads x4 via rs2; hazard unit answers with stall+flush
        set_id(1, 32'h304, 32'h1, 32'h2, 32'h3, 5'd7, 5'd4, 5'd5, 3'b011, 0, 1, 0, 0);
        stall = 1'b1;
        flush = 1'b1;
        expect_out("load_use_detect",
                   mk(1, 32'h50, 32'h70, 3'b000, 32'h60, 32'h300, 5'd4, 1, 1, 0, 1), m_all);
        cycle();

        stall = 1'b0;
        flush = 1'b0;
        expect_out("load_use_bubble", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_ctrl);
        cycle();

        set_id(1, 32'h400, 32'hA, 32'hB, 32'hC, 5'd8, 5'd9, 5'd6, 3'b100, 0, 1, 0, 0);
        expect_out("recapture_after_bubble",
                   mk(1, 32'h1, 32'h2, 3'b011, 32'h2, 32'h304, 5'd5, 1, 0, 0, 0), m_all);
        cycle();

        // ALU producer in EX (rd=6) read by the instruction in decode
        set_id(1, 32'h404, 32'h0, 32'h0, 32'h0, 5'd6, 5'd0, 5'd2, 3'b000, 1, 1, 0, 0);
        expect_out("alu_raw_hazard",
                   mk(1, 32'hA, 32'hB, 3'b100, 32'hB, 32'h400, 5'd6, 1, 0, 0, FWD_EN ? 1'b0 : 1'b1), m_all);
        cycle();

        stall = 1'b1;
        flush = 1'b1;
        expect_out("pre_flush",
                   mk(1, 32'h0, 32'h0, 3'b000, 32'h0, 32'h404, 5'd2, 1, 0, 0, 0), m_all);
        cycle();

        stall = 1'b0;
        flush = 1'b0;
        set_id(0, 32'h900, 32'h12, 32'h34, 32'h56, 5'd1, 5'd2, 5'd9, 3'b101, 0, 1, 1, 1);
        expect_out("stall_flush_bubble", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_ctrl);
        cycle();

        set_id(1, 32'h500, 32'h33, 32'h44, 32'h55, 5'd1, 5'd2, 5'd3, 3'b111, 0, 1, 0, 0);
        expect_out("invalid_slot_bubble", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_ctrl);
        cycle();

        stall = 1'b1;
        set_id(1, 32'h600, 32'hDE, 32'hAD, 32'hBE, 5'd12, 5'd13, 5'd14, 3'b010, 1, 0, 0, 1);
        expect_out("capture_srl",
                   mk(1, 32'h33, 32'h44, 3'b111, 32'h44, 32'h500, 5'd3, 1, 0, 0, 0), m_all);
        cycle();

        // reset arrives while the instruction is held
        rst_n = 1'b0;
        expect_out("reset_mid_stall", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_all);
        cycle();

        rst_n = 1'b1;
        stall = 1'b0;
        set_id(1, 32'h700, 32'h77, 32'h0, 32'h1, 5'd2, 5'd3, 5'd1, 3'b000, 1, 1, 0, 0);
        expect_out("reset_discards_held", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0), m_all);
        cycle();

        set_id(0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 0, 0, 0, 0);
        expect_out("capture_after_reset",
                   mk(1, 32'h77, 32'h1, 3'b000, 32'h0, 32'h700, 5'd1, 1, 0, 0, 0), m_all);
        cycle();

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; parameter REGW, default 5, register-address width.
REQ-002 SHALL have: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have decode inputs: id_valid 1, id_pc XLEN, id_rs1_data XLEN, id_rs2_data XLEN, id_imm XLEN, id_rs1 REGW, id_rs2 REGW, id_rd REGW, id_alu_control 3, id_alu_src 1 (1=imm), id_reg_write 1, id_mem_read 1, id_mem_write 1.
REQ-004 SHALL have control inputs: stall 1 (hold register), flush 1 (insert bubble).
REQ-005 SHALL have forwarding inputs: mem_rd REGW, mem_reg_write 1, mem_result XLEN, wb_rd REGW, wb_reg_write 1, wb_result XLEN.
REQ-006 SHALL have outputs: ex_valid 1, alu_a XLEN, alu_b XLEN, alu_control 3 (to ALU), ex_store_data XLEN, ex_pc XLEN, ex_rd REGW, ex_reg_write 1, ex_mem_read 1, ex_mem_write 1, load_use_stall 1.

Function
REQ-007 SHALL register all id_* inputs on rising clk when stall=0 and flush=0; latency exactly one cycle from decode to ALU operands.
REQ-008 SHALL, when flush=1, load a bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write =0, ex_rd=0, alu_control=000; flush has priority over stall.
REQ-009 SHALL, when stall=1 and flush=0, hold every registered field unchanged.
REQ-010 SHALL, when id_valid=0, capture it as a bubble (same control zeroing as REQ-008).
REQ-011 SHALL select forwarded rs1 operand combinationally: mem_result if mem_reg_write=1, mem_rd!=0, mem_rd==ex_rs1; else wb_result if wb_reg_write=1, wb_rd!=0, wb_rd==ex_rs1; else registered rs1 data; MEM match beats WB match.
REQ-012 SHALL apply REQ-011 identically to rs2 to produce ex_store_data.
REQ-013 SHALL drive alu_a = forwarded rs1; alu_b = registered imm if alu_src=1, else forwarded rs2.
REQ-014 SHALL never forward for register x0 (rd==0), even if reg_write=1.
REQ-015 SHALL assert load_use_stall combinationally when ex_valid=1, ex_mem_read=1, ex_rd!=0 and (ex_rd==id_rs1 or ex_rd==id_rs2) with id_valid=1; hazard logic uses it to drive stall upstream and flush here.
REQ-016 SHALL keep all forwarding and hazard paths free of state beyond the pipeline register itself.

Reset
REQ-017 SHALL, on rst_n=0, asynchronously clear all registered fields to 0; outputs thereby read ex_valid=0, alu_a=0, alu_b=0, alu_control=000, all write/mem enables 0, load_use_stall=0.
REQ-018 SHALL resume capture on the first rising clk after rst_n deasserts; reset asserted mid-stall discards the held instruction.

Configuration
REQ-019 SHALL honour macro ID_EX_FORWARDING_EN: defined -> REQ-011/012 forwarding active; undefined -> alu_a/ex_store_data use registered register data only, mem_*/wb_* inputs ignored, and load_use_stall asserts on any RAW match with ex_rd when ex_reg_write=1 (not only loads).

Structure
REQ-020 SHALL take ALU opcode constants (ADD=000 ... SRL=111) and forwarding-select encodings (REG, MEM, WB) from the shared package pipeline_pkg.
REQ-021 SHALL instantiate one sub-module, fwd_mux, used twice (rs1, rs2), implementing REQ-011 priority.

Verification
REQ-022 Reset: rst_n=0 mid-stream with valid data -> all outputs 0 immediately, before next clk edge.
REQ-023 Basic capture: id_rs1_data=5, id_imm=7, id_alu_src=1, id_alu_control=000 -> next cycle alu_a=5, alu_b=7, alu_control=000.
REQ-024 Forward priority: ex_rs1=3, mem_rd=3 mem_result=0xAA, wb_rd=3 wb_result=0xBB, both reg_write=1 -> alu_a=0xAA; drop mem_reg_write -> alu_a=0xBB; mem_rd=0 -> no MEM forward.
REQ-025 Load-use: ex_mem_read=1, ex_rd=4, id_rs2=4, id_valid=1 -> load_use_stall=1; with stall+flush applied next cycle ex_valid=0, ex_reg_write=0.
REQ-026 Stall/flush: stall=1 for 3 cycles with changing id_* -> outputs unchanged; stall=1 and flush=1 together -> bubble captured.
REQ-027 Config: build without ID_EX_FORWARDING_EN, mem_rd==ex_rs1 with mem_result=0xAA, registered rs1 data=0x11 -> alu_a=0x11; ALU-producer RAW -> load_use_stall=1.
